// File: rtl/wb_arbiter_if.sv
// Bundles the issue/query, EXU/LSU result and register-file write signals of wb_arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding pipeline's view.
interface wb_arbiter_if;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        i_exu_valid;
  logic        o_exu_ready;
  logic [4:0]  i_exu_rd;
  logic [63:0] i_exu_wdata;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [63:0] i_lsu_wdata;
  logic        o_wen;
  logic [4:0]  o_addr;
  logic [63:0] o_wdata;

  modport slave (
    input  i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr,
    input  i_exu_valid, i_exu_rd, i_exu_wdata,
    input  i_lsu_valid, i_lsu_rd, i_lsu_wdata,
    output o_rs1_busy, o_rs2_busy, o_exu_ready, o_lsu_ready,
    output o_wen, o_addr, o_wdata
  );

  modport master (
    output i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr,
    output i_exu_valid, i_exu_rd, i_exu_wdata,
    output i_lsu_valid, i_lsu_rd, i_lsu_wdata,
    input  o_rs1_busy, o_rs2_busy, o_exu_ready, o_lsu_ready,
    input  o_wen, o_addr, o_wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter (EXU/LSU share one register-file write port) plus a RAW scoreboard.
// Define WB_LSU_PRIO_EN for fixed LSU priority; the default build is round-robin.
module wb_arbiter (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  logic        w_grant_exu;
  logic        w_grant_lsu;
  logic        w_xfer;
  logic [4:0]  w_win_rd;
  logic [63:0] w_win_wdata;
  logic [31:0] w_busy_nxt;

  logic        r_wen;
  logic [4:0]  r_addr;
  logic [63:0] r_wdata;
  logic [31:0] r_busy;

`ifndef WB_LSU_PRIO_EN
  logic        r_last_lsu;
`endif

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    w_grant_exu = 1'b0;
    w_grant_lsu = 1'b0;
    if (rst) begin
      w_grant_exu = 1'b0;
      w_grant_lsu = 1'b0;
    end else if (bus.i_exu_valid && bus.i_lsu_valid) begin
`ifdef WB_LSU_PRIO_EN
      w_grant_lsu = 1'b1;
`else
      if (r_last_lsu) begin
        w_grant_exu = 1'b1;
      end else begin
        w_grant_lsu = 1'b1;
      end
`endif
    end else begin
      w_grant_exu = bus.i_exu_valid;
      w_grant_lsu = bus.i_lsu_valid;
    end
  end

  assign w_xfer          = w_grant_exu | w_grant_lsu;
  assign bus.o_exu_ready = w_grant_exu;
  assign bus.o_lsu_ready = w_grant_lsu;

  // Winner payload mux
  always_comb begin
    w_win_rd    = bus.i_exu_rd;
    w_win_wdata = bus.i_exu_wdata;
    if (w_grant_lsu) begin
      w_win_rd    = bus.i_lsu_rd;
      w_win_wdata = bus.i_lsu_wdata;
    end else begin
      w_win_rd    = bus.i_exu_rd;
      w_win_wdata = bus.i_exu_wdata;
    end
  end

`ifndef WB_LSU_PRIO_EN
  // Round-robin history: reset to LSU so EXU wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b1;
    end else if (w_xfer) begin
      r_last_lsu <= w_grant_lsu;
    end
  end
`endif

  // Registered write port; rd 0 is accepted but never written
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_addr  <= 5'd0;
      r_wdata <= 64'd0;
    end else if (w_xfer) begin
      r_wen   <= (w_win_rd != 5'd0);
      r_addr  <= w_win_rd;
      r_wdata <= w_win_wdata;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // Scoreboard next state: clear the retiring write first so a same-cycle issue wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) begin
      w_busy_nxt[r_addr] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) begin
      w_busy_nxt[bus.i_issue_rd] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // The register file forwards this cycle's write, so that register already reads as ready
  assign bus.o_rs1_busy = r_busy[bus.i_rs1_addr] & ~(r_wen & (r_addr == bus.i_rs1_addr));
  assign bus.o_rs2_busy = r_busy[bus.i_rs2_addr] & ~(r_wen & (r_addr == bus.i_rs2_addr));

  assign bus.o_wen   = r_wen;
  assign bus.o_addr  = r_addr;
  assign bus.o_wdata = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a directed sequence followed by random traffic, checked
// against a transaction-level model of arbitration, write-back and register pending state.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        er;
    logic        lr;
    logic        b1;
    logic        b2;
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] wdata;
  } cyc_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] d;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the set of registers with a write outstanding, the write on the port now,
  // and who won the most recent transfer.
  bit          pend [32];
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [63:0] m_wdata;
  bit          last_was_lsu;
  bit          m_ge;
  bit          m_gl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit visible_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_wen && (m_addr == a)) return 1'b0;
    return pend[a];
  endfunction

  // Advance the model across a clock edge using the inputs that were sampled at it
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      m_wen        = 1'b0;
      m_addr       = 5'd0;
      m_wdata      = 64'd0;
      last_was_lsu = 1'b1;
    end else begin
      if (m_wen) pend[m_addr] = 1'b0;
      if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) pend[bus.i_issue_rd] = 1'b1;
      if (m_ge) begin
        m_wen = (bus.i_exu_rd != 5'd0); m_addr = bus.i_exu_rd; m_wdata = bus.i_exu_wdata;
        last_was_lsu = 1'b0;
      end else if (m_gl) begin
        m_wen = (bus.i_lsu_rd != 5'd0); m_addr = bus.i_lsu_rd; m_wdata = bus.i_lsu_wdata;
        last_was_lsu = 1'b1;
      end else begin
        m_wen = 1'b0;
      end
    end
    #1;
  endtask

  // Decide who wins with the current inputs and queue the expected responses
  task automatic apply();
    cyc_t c;
    wr_t  w;
    m_ge = 1'b0;
    m_gl = 1'b0;
    if (!rst) begin
      if (bus.i_exu_valid && bus.i_lsu_valid) begin
`ifdef WB_LSU_PRIO_EN
        m_gl = 1'b1;
`else
        m_ge = last_was_lsu;
        m_gl = !last_was_lsu;
`endif
      end else begin
        m_ge = bus.i_exu_valid;
        m_gl = bus.i_lsu_valid;
      end
    end
    c.er = m_ge; c.lr = m_gl;
    c.b1 = visible_busy(bus.i_rs1_addr);
    c.b2 = visible_busy(bus.i_rs2_addr);
    c.wen = m_wen; c.addr = m_addr; c.wdata = m_wdata;
    cq.push_back(c);
    if (m_ge && (bus.i_exu_rd != 5'd0)) begin
      w.rd = bus.i_exu_rd; w.d = bus.i_exu_wdata; wq.push_back(w);
    end
    if (m_gl && (bus.i_lsu_rd != 5'd0)) begin
      w.rd = bus.i_lsu_rd; w.d = bus.i_lsu_wdata; wq.push_back(w);
    end
  endtask

  task automatic set_in(input logic iv, input logic [4:0] ird, input logic [4:0] r1,
                        input logic [4:0] r2, input logic ev, input logic [4:0] erd,
                        input logic [63:0] ed, input logic lv, input logic [4:0] lrd,
                        input logic [63:0] ld, input logic r);
    bus.i_issue_valid = iv; bus.i_issue_rd = ird;
    bus.i_rs1_addr = r1;    bus.i_rs2_addr = r2;
    bus.i_exu_valid = ev;   bus.i_exu_rd = erd; bus.i_exu_wdata = ed;
    bus.i_lsu_valid = lv;   bus.i_lsu_rd = lrd; bus.i_lsu_wdata = ld;
    rst = r;
  endtask

  task automatic cyc(input logic iv, input logic [4:0] ird, input logic [4:0] r1,
                     input logic [4:0] r2, input logic ev, input logic [4:0] erd,
                     input logic [63:0] ed, input logic lv, input logic [4:0] lrd,
                     input logic [63:0] ld, input logic r);
    tick();
    set_in(iv, ird, r1, r2, ev, erd, ed, lv, lrd, ld, r);
    apply();
  endtask

  // Monitor: compares every cycle's outputs, and the write payload whenever o_wen is high
  cyc_t mon_c;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      mon_c = cq.pop_front();
      chk("exu_ready", {63'd0, bus.o_exu_ready}, {63'd0, mon_c.er});
      chk("lsu_ready", {63'd0, bus.o_lsu_ready}, {63'd0, mon_c.lr});
      chk("rs1_busy",  {63'd0, bus.o_rs1_busy},  {63'd0, mon_c.b1});
      chk("rs2_busy",  {63'd0, bus.o_rs2_busy},  {63'd0, mon_c.b2});
      chk("wen",       {63'd0, bus.o_wen},       {63'd0, mon_c.wen});
      chk("addr",      {59'd0, bus.o_addr},      {59'd0, mon_c.addr});
      chk("wdata",     bus.o_wdata,              mon_c.wdata);
      if (bus.o_wen === 1'b1) begin
        if (wq.size() == 0) begin
          chk("write_expected", 64'd1, 64'd0);
        end else begin
          mon_w = wq.pop_front();
          chk("write_addr",  {59'd0, bus.o_addr}, {59'd0, mon_w.rd});
          chk("write_wdata", bus.o_wdata,         mon_w.d);
        end
      end
    end
  end

  initial begin
    logic        iv, ev, lv, r;
    logic [4:0]  ird, r1, r2, erd, lrd;
    logic [63:0] ed, ld;

    m_ge = 1'b0; m_gl = 1'b0; m_wen = 1'b0; m_addr = 5'd0; m_wdata = 64'd0;
    last_was_lsu = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);

    // Reset, then single issue and write-back of x5
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    // Contention straight after reset
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 5'd0, 5'd3, 5'd4, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    // rd 0 is accepted without a write
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    // Issue x7 in the same cycle its previous write retires
    cyc(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    // Reset in the middle of traffic
    cyc(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd2, 5'd9, 1'b1, 5'd12, 64'hAB, 1'b1, 5'd13, 64'hCD, 1'b0);
    cyc(1'b0, 5'd0, 5'd2, 5'd9, 1'b1, 5'd12, 64'hAB, 1'b1, 5'd13, 64'hCD, 1'b1);
    cyc(1'b0, 5'd0, 5'd2, 5'd9, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    // Random traffic; losers hold their payload and decode honours the WAW stall
    ev = 1'b0; erd = 5'd0; ed = 64'd0;
    lv = 1'b0; lrd = 5'd0; ld = 64'd0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!(ev && !m_ge)) begin
        ev  = ($urandom_range(2) != 0);
        erd = 5'($urandom_range(31));
        ed  = {$urandom, $urandom};
      end
      if (!(lv && !m_gl)) begin
        lv  = ($urandom_range(2) != 0);
        lrd = 5'($urandom_range(31));
        ld  = {$urandom, $urandom};
      end
      ird = 5'($urandom_range(31));
      iv  = ($urandom_range(1) != 0) && !visible_busy(ird);
      r1  = ($urandom_range(1) != 0) ? m_addr : 5'($urandom_range(31));
      r2  = 5'($urandom_range(31));
      r   = ($urandom_range(99) == 0);
      set_in(iv, ird, r1, r2, ev, erd, ed, lv, lrd, ld, r);
      apply();
    end

    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("writes_drained", 64'(wq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
